// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter unit.
package pc_pkg;

    localparam int unsigned XLEN_DEF        = 32;
    localparam int unsigned INSTR_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        HOLD   = 2'd3
    } pc_src_e;

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// Next-PC priority mux and adders; handles misaligned redirect targets.
// Define PC_MISALIGN_TRAP_EN to divert misaligned targets to TRAP_VEC instead of aligning them.
module pc_next_sel import pc_pkg::*; #(
    parameter int unsigned     XLEN        = XLEN_DEF,
    parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100)
) (
    input  logic                   clk_unused_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic                   run_i,
    input  logic                   finish_i,
    input  logic                   stall_i,
    input  logic                   jump_i,
    input  logic [XLEN-1:0]        jump_target_i,
    input  logic                   branch_i,
    input  logic signed [XLEN-1:0] branch_offset_i,
    output logic [XLEN-1:0]        pc_next_o,
    output pc_src_e                src_o,
    output logic                   misalign_o
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] target;
    logic            redirect;
    logic            unused_clk;

    assign unused_clk = clk_unused_i;

    // Priority: finish/stall hold, then jump, branch, sequential.
    always_comb begin
        pc_next_o  = pc_i;
        src_o      = HOLD;
        misalign_o = 1'b0;
        target     = '0;
        redirect   = 1'b0;

        if (run_i && !finish_i && !stall_i) begin
            if (jump_i) begin
                target   = jump_target_i;
                redirect = 1'b1;
                src_o    = JUMP;
            end else if (branch_i) begin
                target   = pc_i + $unsigned(branch_offset_i);
                redirect = 1'b1;
                src_o    = BRANCH;
            end else begin
                pc_next_o = pc_i + XLEN'(INSTR_BYTES);
                src_o     = SEQ;
            end
        end

        if (redirect) begin
            if (TRAP_EN && ((target & LOW_MASK) != '0)) begin
                pc_next_o  = TRAP_VEC;
                misalign_o = 1'b1;
            end else begin
                pc_next_o = target & ~LOW_MASK;
            end
        end
    end

endmodule : pc_next_sel

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT sequencing; optional misaligned-redirect trap
// selected by PC_MISALIGN_TRAP_EN.
module pc_unit import pc_pkg::*; #(
    parameter int unsigned     XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   finish_flag,
    input  logic                   branch,
    input  logic signed [XLEN-1:0] branch_offset,
    input  logic                   jump,
    input  logic [XLEN-1:0]        jump_target,
    output logic signed [XLEN-1:0] pc_reg,
    output logic [XLEN-1:0]        pc_seq,
    output logic                   pc_valid,
    output logic                   halted,
    output logic                   misalign_err
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            misalign_q, misalign_d;

    logic [XLEN-1:0] pc_next;
    pc_src_e         src;
    logic            misalign;

    pc_next_sel #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES),
        .TRAP_VEC    (TRAP_VEC)
    ) u_next_sel (
        .clk_unused_i    (clk),
        .pc_i            (pc_q),
        .run_i           (state_q == RUN),
        .finish_i        (finish_flag),
        .stall_i         (stall),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_i        (branch),
        .branch_offset_i (branch_offset),
        .pc_next_o       (pc_next),
        .src_o           (src),
        .misalign_o      (misalign)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    // BOOT lasts one cycle; HALT is left only through reset.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = 1'b0;
        halted_d   = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (finish_flag) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase

        if (src != HOLD) pc_d = pc_next;

        valid_d    = (state_d == RUN);
        halted_d   = (state_d == HALT);
        misalign_d = misalign;
    end

    assign pc_reg       = pc_q;
    assign pc_seq       = pc_q + XLEN'(INSTR_BYTES);
    assign pc_valid     = valid_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

    logic               clk;
    logic               reset;
    logic               stall;
    logic               finish_flag;
    logic               branch;
    logic signed [31:0] branch_offset;
    logic               jump;
    logic [31:0]        jump_target;
    logic signed [31:0] pc_reg;
    logic [31:0]        pc_seq;
    logic               pc_valid;
    logic               halted;
    logic               misalign_err;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .finish_flag   (finish_flag),
        .branch        (branch),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_reg        (pc_reg),
        .pc_seq        (pc_seq),
        .pc_valid      (pc_valid),
        .halted        (halted),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        stall         = 1'b0;
        finish_flag   = 1'b0;
        branch        = 1'b0;
        branch_offset = '0;
        jump          = 1'b0;
        jump_target   = '0;
    endtask

    task automatic jump_to(input logic [31:0] tgt);
        jump        = 1'b1;
        jump_target = tgt;
        step();
        jump        = 1'b0;
    endtask

    initial begin
        logic exp_mis;
`ifdef PC_MISALIGN_TRAP_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        clear_in();
        reset = 1'b1;
        step();
        step();
        check("rst_pc", pc_reg, 32'h0);
        check("rst_valid", 32'(pc_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_mis", 32'(misalign_err), 32'h0);

        // Boot then sequential fetch
        reset = 1'b0;
        #1;
        check("boot_valid", 32'(pc_valid), 32'h0);
        step();
        check("run_valid", 32'(pc_valid), 32'h1);
        check("seq0", pc_reg, 32'h0);
        step();
        check("seq4", pc_reg, 32'h4);
        step();
        check("seq8", pc_reg, 32'h8);
        check("pc_seq8", pc_seq, 32'hC);
        step();
        step();
        check("seq10", pc_reg, 32'h10);

        // Backward branch then absolute jump
        branch        = 1'b1;
        branch_offset = -32'sd8;
        step();
        check("branch_neg", pc_reg, 32'h08);
        branch = 1'b0;
        jump_to(32'h200);
        check("jump200", pc_reg, 32'h200);

        // Jump beats branch; stall beats both
        jump_to(32'h20);
        check("at20", pc_reg, 32'h20);
        branch        = 1'b1;
        branch_offset = 32'sd64;
        jump          = 1'b1;
        jump_target   = 32'h80;
        stall         = 1'b1;
        step();
        check("stall_hold", pc_reg, 32'h20);
        check("stall_valid", 32'(pc_valid), 32'h1);
        stall = 1'b0;
        step();
        check("jump_prio", pc_reg, 32'h80);
        clear_in();

        // Misaligned redirect
        jump_to(32'h102);
        check("mis_pc", pc_reg, 32'h100);
        check("mis_err", 32'(misalign_err), 32'(exp_mis));
        step();
        check("mis_pulse_end", 32'(misalign_err), 32'h0);
        check("mis_next", pc_reg, 32'h104);

        // Halt freezes PC regardless of redirects
        jump_to(32'h30);
        check("at30", pc_reg, 32'h30);
        finish_flag = 1'b1;
        step();
        finish_flag = 1'b0;
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_valid", 32'(pc_valid), 32'h0);
        branch        = 1'b1;
        branch_offset = 32'sd16;
        jump          = 1'b1;
        jump_target   = 32'h500;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_frozen", pc_reg, 32'h30);
        end
        check("halt_still", 32'(halted), 32'h1);

        // Async reset from HALT
        reset = 1'b1;
        #1;
        check("halt_rst_pc", pc_reg, 32'h0);
        check("halt_rst_halted", 32'(halted), 32'h0);
        clear_in();
        step();
        reset = 1'b0;

        // finish_flag during BOOT is ignored
        finish_flag = 1'b1;
        step();
        check("boot_finish_ign", 32'(halted), 32'h0);
        check("boot_finish_valid", 32'(pc_valid), 32'h1);
        finish_flag = 1'b0;

        // Wrap-around
        jump_to(32'hFFFF_FFFC);
        check("at_top", pc_reg, 32'hFFFF_FFFC);
        check("pc_seq_wrap", pc_seq, 32'h0);
        step();
        check("wrap0", pc_reg, 32'h0);
        step();
        check("wrap4", pc_reg, 32'h4);

        // Reset mid-cycle takes effect before the next edge
        reset = 1'b1;
        #2;
        check("mid_rst_pc", pc_reg, 32'h0);
        check("mid_rst_valid", 32'(pc_valid), 32'h0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_pc", pc_reg, 32'h0);
        step();
        check("post_rst_seq", pc_reg, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pc_unit
